// File: rtl/ungapped_extension_ctrl.sv
// ungapped_extension_ctrl: BLAST-N ungapped extension sequencer.
// Scores base pairs +2/-1, tracks best score/length, stops on X-drop or end of sequence.
module ungapped_extension_ctrl #(
    parameter int SCORE_W = 12,
    parameter int LEN_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [LEN_W-1:0]          max_len,
    input  logic [SCORE_W-1:0]        xdrop,
    output logic                      base_req,
    output logic [LEN_W-1:0]          base_idx,
    input  logic                      base_vld,
    input  logic [1:0]                query_base,
    input  logic [1:0]                subj_base,
    output logic                      busy,
    output logic                      done,
    output logic signed [SCORE_W-1:0] best_score,
    output logic [LEN_W-1:0]          best_len,
    output logic                      stop_reason
);
    typedef enum logic [1:0] {IDLE, FETCH, ACCUM, DONE} state_t;

    state_t                    state_q, state_d;
    logic [LEN_W-1:0]          idx_q, idx_d, max_len_q, max_len_d, best_len_q, best_len_d, idx_inc;
    logic [SCORE_W-1:0]        xdrop_q, xdrop_d, gap;
    logic signed [SCORE_W-1:0] run_q, run_d, best_q, best_d, run_nx, best_nx;
    logic [1:0]                qb_q, qb_d, sb_q, sb_d;
    logic                      stop_q, stop_d, req_q, req_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        max_len_d  = max_len_q;
        xdrop_d    = xdrop_q;
        run_d      = run_q;
        best_d     = best_q;
        best_len_d = best_len_q;
        stop_d     = stop_q;
        qb_d       = qb_q;
        sb_d       = sb_q;
        idx_inc    = idx_q + LEN_W'(1);
        run_nx     = (qb_q == sb_q) ? run_q + SCORE_W'(2) : run_q - SCORE_W'(1);
        best_nx    = (run_nx > best_q) ? run_nx : best_q;
        // best never trails run, so the gap is a non-negative magnitude
        gap        = best_nx - run_nx;
        case (state_q)
            IDLE: begin
                if (start) begin
                    max_len_d  = max_len;
                    xdrop_d    = xdrop;
                    idx_d      = '0;
                    run_d      = '0;
                    best_d     = '0;
                    best_len_d = '0;
                    stop_d     = 1'b0;
                    state_d    = (max_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (base_vld) begin
                    qb_d    = query_base;
                    sb_d    = subj_base;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                run_d      = run_nx;
                best_d     = best_nx;
                best_len_d = (run_nx > best_q) ? idx_inc : best_len_q;
                if (gap >= xdrop_q) begin
                    stop_d  = 1'b1;
                    state_d = DONE;
                end else if (idx_inc == max_len_q) begin
                    stop_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_inc;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        req_d  = (state_d == FETCH);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            max_len_q  <= '0;
            xdrop_q    <= '0;
            run_q      <= '0;
            best_q     <= '0;
            best_len_q <= '0;
            stop_q     <= 1'b0;
            qb_q       <= '0;
            sb_q       <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            max_len_q  <= max_len_d;
            xdrop_q    <= xdrop_d;
            run_q      <= run_d;
            best_q     <= best_d;
            best_len_q <= best_len_d;
            stop_q     <= stop_d;
            qb_q       <= qb_d;
            sb_q       <= sb_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign base_req    = req_q;
    assign base_idx    = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign best_score  = best_q;
    assign best_len    = best_len_q;
    assign stop_reason = stop_q;
endmodule

// File: tb/tb_ungapped_extension_ctrl.sv
// tb_ungapped_extension_ctrl: directed jobs with a result scoreboard and a base-pair responder.
module tb_ungapped_extension_ctrl;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        max_len = '0;
    logic [11:0]       xdrop = '0;
    logic              base_req, base_vld = 1'b0;
    logic [7:0]        base_idx;
    logic [1:0]        query_base = '0, subj_base = '0;
    logic              busy, done, stop_reason;
    logic signed [11:0] best_score;
    logic [7:0]        best_len;

    typedef struct {int sc; int ln; int rs; int nb; int lat; int t0;} exp_t;
    exp_t       exp_q[$];
    int         errors = 0, checks = 0, cyc = 0, n_exp = 0, n_done = 0;
    int         job_id = 0, xfer = 0;
    int         stall_rem[16];
    logic [1:0] qa[16], sa[16];
    bit         vld_tied = 1'b0;

    ungapped_extension_ctrl #(.SCORE_W(12), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .max_len(max_len), .xdrop(xdrop),
        .base_req(base_req), .base_idx(base_idx), .base_vld(base_vld),
        .query_base(query_base), .subj_base(subj_base), .busy(busy), .done(done),
        .best_score(best_score), .best_len(best_len), .stop_reason(stop_reason)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Responder: serves pairs from qa/sa, inserts per-index stalls, counts transfers
    initial begin
        int  seen = 0;
        bit  prev = 1'b0;
        forever begin
            @(negedge clk);
            if (job_id != seen) begin
                seen = job_id;
                xfer = 0;
                prev = 1'b0;
            end else if (prev) xfer++;
            if (base_req) begin
                chk("base_idx", int'(base_idx), xfer);
                query_base = qa[base_idx[3:0]];
                subj_base  = sa[base_idx[3:0]];
                if (!vld_tied && stall_rem[base_idx[3:0]] > 0) begin
                    stall_rem[base_idx[3:0]]--;
                    base_vld = 1'b0;
                end else base_vld = 1'b1;
            end else base_vld = vld_tied;
            prev = base_req && base_vld;
        end
    end

    // Monitor: pops the expected result on every done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("best_score", int'(best_score), e.sc);
                    chk("best_len", int'(best_len), e.ln);
                    chk("stop_reason", int'(stop_reason), e.rs);
                    chk("bases_fetched", xfer, e.nb);
                    chk("done_latency", cyc - e.t0, e.lat);
                end
                n_done++;
            end
        end
    end

    task automatic chk_reset(input string nm);
        chk({nm, "_ctl"}, int'({busy, base_req, done, stop_reason}), 0);
        chk({nm, "_data"}, int'({best_score, best_len, base_idx}), 0);
    endtask

    // mode: 0 = base_vld tied high, 1 = random 0-3 stalls, 2 = endless stall at index 2
    task automatic run_job(input logic [15:0] m, input int ml, input int xd, input int es,
                           input int el, input int er, input int nb, input int mode,
                           input bit poke, input int abort_at);
        int st = 0;
        @(negedge clk);
        job_id++;
        for (int i = 0; i < 16; i++) begin
            qa[i] = 2'(i);
            sa[i] = m[i] ? 2'(i) : 2'(i + 1);
            stall_rem[i] = (mode == 1) ? int'($urandom_range(0, 3)) : ((mode == 2 && i == 2) ? 30 : 0);
            if (i < nb) st += stall_rem[i];
        end
        vld_tied = (mode == 0);
        if (abort_at == 0) begin
            exp_q.push_back('{es, el, er, nb, 2 * nb + 1 + st, cyc});
            n_exp++;
        end
        start = 1'b1; max_len = 8'(ml); xdrop = 12'(xd);
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (2) @(negedge clk);
            start = 1'b1; max_len = 8'd0;
            @(negedge clk);
            start = 1'b0;
        end
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk);
            chk("pre_abort_busy", int'(busy), 1);
            rst_n = 1'b0;
            #1;
            chk_reset("abort");
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end else begin
            for (int k = 0; k < 400 && n_done < n_exp; k++) @(negedge clk);
            if (n_done < n_exp) chk("done_timeout", n_done, n_exp);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        run_job(16'hFFFF, 4, 10, 8, 4, 0, 4, 0, 0, 0);
        run_job(16'h0003, 8, 3, 4, 2, 1, 5, 0, 0, 0);
        run_job(16'h0013, 5, 10, 4, 2, 0, 5, 0, 0, 0);
        run_job(16'h0000, 0, 10, 0, 0, 0, 0, 0, 0, 0);
        run_job(16'h0001, 8, 0, 2, 1, 1, 1, 0, 0, 0);
        run_job(16'h0003, 8, 3, 4, 2, 1, 5, 1, 1, 0);
        run_job(16'h0013, 5, 10, 4, 2, 0, 5, 1, 0, 0);
        run_job(16'h0000, 3, 10, 0, 0, 0, 3, 0, 0, 0);
        run_job(16'hFFFF, 8, 100, 0, 0, 0, 0, 0, 0, 6);
        run_job(16'hFFFF, 8, 100, 0, 0, 0, 0, 2, 0, 6);
        run_job(16'hFFFF, 4, 10, 8, 4, 0, 4, 0, 0, 0);
        run_job(16'hFFFF, 16, 5, 32, 16, 0, 16, 1, 0, 0);
        repeat (5) @(negedge clk);
        chk("leftover_expected", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
